// File: rtl/pcm_packetizer.sv
// -----------------------------------------------------------------------------
// pcm_packetizer
// Captures NUM_CH parallel PCM samples per strobe, serialises them
// channel-interleaved (ch0 first) into a first-word-fall-through FIFO, and
// emits fixed-length AXI-Stream packets. Each packet optionally starts with a
// header word carrying a 16-bit sequence number. A packet is only started once
// a full payload is buffered, so tvalid never gaps inside a packet.
//
// Ports:
//   clk, rst_n        single clock, asynchronous active-low reset
//   s_data, s_valid   one-cycle sample-set strobe, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   m_axis_*          AXI-Stream master (tdata/tvalid/tready/tlast)
//   seq_num           sequence number of the next packet to start
//   drop_count        saturating count of discarded sample sets
//   overflow          one-cycle pulse per discarded sample set
// -----------------------------------------------------------------------------
module pcm_packetizer #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned SAMPLE_W      = 32,
  parameter int unsigned PAYLOAD_WORDS = 128,
  parameter int unsigned FIFO_DEPTH    = 512,
  parameter bit          HDR_EN        = 1'b1,
  parameter bit          SWAP_BYTES    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*SAMPLE_W-1:0] s_data,
  input  logic                       s_valid,
  output logic [SAMPLE_W-1:0]        m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [15:0]                seq_num,
  output logic [15:0]                drop_count,
  output logic                       overflow
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CW       = AW + 1;
  localparam int unsigned SCW      = $clog2(NUM_CH + 1);
  localparam int unsigned WCW      = $clog2(PAYLOAD_WORDS + 1);
  localparam int unsigned NB       = SAMPLE_W / 8;
  localparam bit          ONE_WORD = (PAYLOAD_WORDS == 1);

  // Elaboration-time parameter sanity checks
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("pcm_packetizer: NUM_CH must be in 1..8");
  end
  if (SAMPLE_W < 32 || (SAMPLE_W % 8) != 0) begin : g_bad_sample_w
    $error("pcm_packetizer: SAMPLE_W must be >= 32 and a whole number of bytes");
  end
  if ((PAYLOAD_WORDS % NUM_CH) != 0) begin : g_bad_payload
    $error("pcm_packetizer: PAYLOAD_WORDS must be a multiple of NUM_CH");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2 * PAYLOAD_WORDS) begin : g_bad_depth
    $error("pcm_packetizer: FIFO_DEPTH must be a power of 2 and >= 2*PAYLOAD_WORDS");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2
  } state_t;

  // Optional byte reversal of one output word
  function automatic logic [SAMPLE_W-1:0] f_swap(input logic [SAMPLE_W-1:0] d);
    logic [SAMPLE_W-1:0] r;
    r = d;
    if (SWAP_BYTES) begin
      for (int unsigned i = 0; i < NB; i++) begin
        r[i*8 +: 8] = d[(NB-1-i)*8 +: 8];
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [NUM_CH*SAMPLE_W-1:0] r_ser_data;
  logic [SCW-1:0]             r_ser_left;
  logic [SAMPLE_W-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]              r_wr_ptr;
  logic [AW-1:0]              r_rd_ptr;
  logic [CW-1:0]              r_count;
  state_t                     r_state;
  logic [WCW-1:0]             r_wcnt;

  logic                       w_ser_busy;
  logic                       w_room;
  logic                       w_accept;
  logic                       w_drop;
  logic                       w_wr;
  logic                       w_rd;
  logic                       w_pkt_ready;
  logic [SAMPLE_W-1:0]        w_wr_data;
  logic [SAMPLE_W-1:0]        w_head;
  logic [SAMPLE_W-1:0]        w_hdr;

  // ---------------------------------------------------------------------------
  // Capture / drop decision
  // ---------------------------------------------------------------------------
  // A set is accepted only when the serializer is idle, so no writes are
  // pending and free slots reduce to FIFO_DEPTH - count.
  assign w_ser_busy = (r_ser_left != '0);
  assign w_room     = (r_count <= CW'(FIFO_DEPTH - NUM_CH));
  assign w_accept   = s_valid && !w_ser_busy && w_room;
  assign w_drop     = s_valid && !w_accept;

  // Serializer: shift register emitting ch0 first, one word per busy cycle
  assign w_wr      = w_ser_busy;
  assign w_wr_data = r_ser_data[SAMPLE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ser_data <= '0;
      r_ser_left <= '0;
    end else if (w_accept) begin
      r_ser_data <= s_data;
      r_ser_left <= SCW'(NUM_CH);
    end else if (w_ser_busy) begin
      r_ser_data <= r_ser_data >> SAMPLE_W;
      r_ser_left <= r_ser_left - SCW'(1);
    end
  end

  // Overflow pulse and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= 16'h0000;
    end else begin
      overflow <= w_drop;
      if (w_drop && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT FIFO
  // ---------------------------------------------------------------------------
  // Storage array carries no reset; pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  // tdata is registered: a payload word is popped from the FIFO at the moment
  // it is loaded into the output register, so the head is always the word
  // that follows the one currently presented.
  assign w_pkt_ready = (r_count >= CW'(PAYLOAD_WORDS));
  assign w_hdr       = SAMPLE_W'({8'hA5, 8'(NUM_CH), seq_num});

  assign w_rd = ((r_state == S_IDLE) && w_pkt_ready && !HDR_EN) ||
                ((r_state == S_HDR)  && m_axis_tready) ||
                ((r_state == S_PAY)  && m_axis_tready && !m_axis_tlast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wcnt        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      seq_num       <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pkt_ready) begin
            m_axis_tvalid <= 1'b1;
            if (HDR_EN) begin
              r_state      <= S_HDR;
              m_axis_tdata <= f_swap(w_hdr);
              m_axis_tlast <= 1'b0;
            end else begin
              r_state      <= S_PAY;
              m_axis_tdata <= f_swap(w_head);
              m_axis_tlast <= ONE_WORD;
              r_wcnt       <= WCW'(1);
            end
          end
        end
        S_HDR: begin
          if (m_axis_tready) begin
            r_state      <= S_PAY;
            m_axis_tdata <= f_swap(w_head);
            m_axis_tlast <= ONE_WORD;
            r_wcnt       <= WCW'(1);
          end
        end
        S_PAY: begin
          if (m_axis_tready) begin
            if (m_axis_tlast) begin
              // Packet done: forced IDLE cycle gives the inter-packet gap
              r_state       <= S_IDLE;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              m_axis_tdata  <= '0;
              seq_num       <= seq_num + 16'd1;
            end else begin
              // r_wcnt is the 0-based index of the word being loaded
              m_axis_tdata <= f_swap(w_head);
              m_axis_tlast <= (r_wcnt == WCW'(PAYLOAD_WORDS - 1));
              r_wcnt       <= r_wcnt + WCW'(1);
            end
          end
        end
        default: begin
          r_state       <= S_IDLE;
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_packetizer.sv
// -----------------------------------------------------------------------------
// tb_pcm_packetizer
// Self-checking bench for pcm_packetizer. Two instances: A with header and no
// byte swap, B without header and with byte swap. Expected output words are
// pushed to per-instance queues when stimulus is applied and compared as the
// DUT hands words off; AXIS stall stability and packet gaps are also checked.
// -----------------------------------------------------------------------------
module tb_pcm_packetizer;

  localparam int unsigned NCH   = 2;
  localparam int unsigned SW    = 32;
  localparam int unsigned PW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SETS  = PW / NCH;

  typedef struct packed {
    logic [SW-1:0] data;
    logic          last;
  } word_t;

  typedef struct packed {
    logic [SW-1:0] ch0;
    logic [SW-1:0] ch1;
    logic [SW-1:0] exp0;
    logic [SW-1:0] exp1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH*SW-1:0] a_s_data = '0;
  logic              a_s_valid = 1'b0;
  logic [SW-1:0]     a_tdata;
  logic              a_tvalid;
  logic              a_tready = 1'b1;
  logic              a_tlast;
  logic [15:0]       a_seq;
  logic [15:0]       a_drop;
  logic              a_ovf;

  logic [NCH*SW-1:0] b_s_data = '0;
  logic              b_s_valid = 1'b0;
  logic [SW-1:0]     b_tdata;
  logic              b_tvalid;
  logic              b_tready = 1'b1;
  logic              b_tlast;
  logic [15:0]       b_seq;
  logic [15:0]       b_drop;
  logic              b_ovf;

  pcm_packetizer #(
    .NUM_CH(NCH), .SAMPLE_W(SW), .PAYLOAD_WORDS(PW), .FIFO_DEPTH(DEPTH),
    .HDR_EN(1'b1), .SWAP_BYTES(1'b0)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .s_data(a_s_data), .s_valid(a_s_valid),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
    .m_axis_tlast(a_tlast), .seq_num(a_seq), .drop_count(a_drop), .overflow(a_ovf)
  );

  pcm_packetizer #(
    .NUM_CH(NCH), .SAMPLE_W(SW), .PAYLOAD_WORDS(PW), .FIFO_DEPTH(DEPTH),
    .HDR_EN(1'b0), .SWAP_BYTES(1'b1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .s_data(b_s_data), .s_valid(b_s_valid),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
    .m_axis_tlast(b_tlast), .seq_num(b_seq), .drop_count(b_drop), .overflow(b_ovf)
  );

  int    checks = 0;
  int    errors = 0;
  word_t q_a[$];
  word_t q_b[$];
  bit    tog_en = 1'b0;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input bit sel, input logic [SW-1:0] d, input logic l);
    word_t w;
    w.data = d;
    w.last = l;
    if (sel) q_b.push_back(w);
    else     q_a.push_back(w);
  endtask

  function automatic logic [SW-1:0] hdr_word(input logic [15:0] seq);
    return {8'hA5, 8'(NCH), seq};
  endfunction

  // One-cycle strobe followed by enough idle cycles for the serializer
  task automatic strobe(input bit sel, input logic [SW-1:0] c0, input logic [SW-1:0] c1);
    @(posedge clk); #1;
    if (sel) begin b_s_data = {c1, c0}; b_s_valid = 1'b1; end
    else     begin a_s_data = {c1, c0}; a_s_valid = 1'b1; end
    @(posedge clk); #1;
    a_s_valid = 1'b0;
    b_s_valid = 1'b0;
    repeat (NCH) @(posedge clk);
  endtask

  // Wait (bounded) for the scoreboard to empty and the stream to go idle
  task automatic drain(input bit sel, input int max_cyc);
    int n = 0;
    while (n < max_cyc && (sel ? (q_b.size() != 0 || b_tvalid) : (q_a.size() != 0 || a_tvalid))) begin
      @(negedge clk);
      n++;
    end
    if (sel) chk("b_drain_left", SW'(q_b.size()), '0);
    else     chk("a_drain_left", SW'(q_a.size()), '0);
  endtask

  // Output monitor A: scoreboard pop, stall stability, no mid-packet gap, inter-packet gap
  always @(negedge clk) begin : mon_a
    word_t         w;
    logic          pv, pr, pl, hsn, hsl;
    logic [SW-1:0] pd;
    if (!rst_n) begin
      pv = 1'b0; pr = 1'b0; pl = 1'b0; hsn = 1'b0; hsl = 1'b0; pd = '0;
    end else begin
      if (pv && !pr) begin
        chk("a_stall_valid", SW'(a_tvalid), 32'd1);
        chk("a_stall_data", a_tdata, pd);
        chk("a_stall_last", SW'(a_tlast), SW'(pl));
      end
      if (hsn) chk("a_no_gap", SW'(a_tvalid), 32'd1);
      if (hsl) chk("a_ipg", SW'(a_tvalid), 32'd0);
      if (a_tvalid && a_tready) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_extra_word: got %h expected none", a_tdata);
        end else begin
          w = q_a.pop_front();
          chk("a_data", a_tdata, w.data);
          chk("a_last", SW'(a_tlast), SW'(w.last));
        end
      end
      pv  = a_tvalid;
      pr  = a_tready;
      pd  = a_tdata;
      pl  = a_tlast;
      hsn = a_tvalid && a_tready && !a_tlast;
      hsl = a_tvalid && a_tready && a_tlast;
    end
  end

  // Output monitor B
  always @(negedge clk) begin : mon_b
    word_t w;
    logic  hsn, hsl;
    if (!rst_n) begin
      hsn = 1'b0; hsl = 1'b0;
    end else begin
      if (hsn) chk("b_no_gap", SW'(b_tvalid), 32'd1);
      if (hsl) chk("b_ipg", SW'(b_tvalid), 32'd0);
      if (b_tvalid && b_tready) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_extra_word: got %h expected none", b_tdata);
        end else begin
          w = q_b.pop_front();
          chk("b_data", b_tdata, w.data);
          chk("b_last", SW'(b_tlast), SW'(w.last));
        end
      end
      hsn = b_tvalid && b_tready && !b_tlast;
      hsl = b_tvalid && b_tready && b_tlast;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t va[SETS];
    vec_t vb[SETS];

    // Pass-through vectors for A (no swap) and byte-swap vectors for B
    va[0] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000};
    va[1] = '{32'h0000_1001, 32'h0000_2001, 32'h0000_1001, 32'h0000_2001};
    va[2] = '{32'h0000_1002, 32'h0000_2002, 32'h0000_1002, 32'h0000_2002};
    va[3] = '{32'h0000_1003, 32'h0000_2003, 32'h0000_1003, 32'h0000_2003};
    vb[0] = '{32'h1122_3344, 32'hDEAD_BEEF, 32'h4433_2211, 32'hEFBE_ADDE};
    vb[1] = '{32'h0102_0304, 32'hA5A5_F00F, 32'h0403_0201, 32'h0FF0_A5A5};
    vb[2] = '{32'h0000_0001, 32'h8000_0000, 32'h0100_0000, 32'h0000_0080};
    vb[3] = '{32'hCAFE_BABE, 32'h1234_5678, 32'hBEBA_FECA, 32'h7856_3412};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tvalid", SW'(a_tvalid), 32'd0);
    chk("rst_tdata", a_tdata, 32'd0);
    chk("rst_tlast", SW'(a_tlast), 32'd0);
    chk("rst_seq", SW'(a_seq), 32'd0);
    chk("rst_drop", SW'(a_drop), 32'd0);
    chk("rst_ovf", SW'(a_ovf), 32'd0);
    chk("rst_b_tvalid", SW'(b_tvalid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic packet with header, tready=1
    push(1'b0, hdr_word(16'd0), 1'b0);
    for (int k = 0; k < int'(SETS); k++) begin
      push(1'b0, va[k].exp0, 1'b0);
      push(1'b0, va[k].exp1, k == int'(SETS) - 1);
      strobe(1'b0, va[k].ch0, va[k].ch1);
    end
    drain(1'b0, 100);
    chk("a_seq_pkt1", SW'(a_seq), 32'd1);

    // Same packet with tready toggling every cycle
    tog_en = 1'b1;
    fork
      begin
        while (tog_en) begin
          @(posedge clk); #1;
          a_tready = ~a_tready;
        end
      end
    join_none
    push(1'b0, hdr_word(16'd1), 1'b0);
    for (int k = 0; k < int'(SETS); k++) begin
      push(1'b0, va[k].exp0, 1'b0);
      push(1'b0, va[k].exp1, k == int'(SETS) - 1);
      strobe(1'b0, va[k].ch0, va[k].ch1);
    end
    drain(1'b0, 200);
    tog_en = 1'b0;
    repeat (2) @(posedge clk); #1;
    a_tready = 1'b1;
    chk("a_seq_pkt2", SW'(a_seq), 32'd2);

    // Two strobes one cycle apart: second set dropped whole
    push(1'b0, hdr_word(16'd2), 1'b0);
    push(1'b0, 32'h0000_1100, 1'b0);
    push(1'b0, 32'h0000_2100, 1'b0);
    @(posedge clk); #1;
    a_s_data  = {32'h0000_2100, 32'h0000_1100};
    a_s_valid = 1'b1;
    @(posedge clk); #1;
    a_s_data  = {32'h0000_BEEF, 32'h0000_DEAD};
    @(posedge clk); #1;
    a_s_valid = 1'b0;
    @(negedge clk);
    chk("a_ovf_pulse", SW'(a_ovf), 32'd1);
    chk("a_drop_1", SW'(a_drop), 32'd1);
    @(negedge clk);
    chk("a_ovf_single", SW'(a_ovf), 32'd0);
    for (int n = 1; n < int'(SETS); n++) begin
      push(1'b0, 32'h0000_1100 + SW'(n), 1'b0);
      push(1'b0, 32'h0000_2100 + SW'(n), n == int'(SETS) - 1);
      strobe(1'b0, 32'h0000_1100 + SW'(n), 32'h0000_2100 + SW'(n));
    end
    drain(1'b0, 100);
    chk("a_seq_pkt3", SW'(a_seq), 32'd3);

    // Fill the FIFO with tready low, then one more strobe is dropped
    @(posedge clk); #1;
    a_tready = 1'b0;
    for (int n = 0; n < int'(DEPTH / NCH); n++) begin
      if (n % int'(SETS) == 0) push(1'b0, hdr_word(16'(3 + n / int'(SETS))), 1'b0);
      push(1'b0, 32'h0000_1200 + SW'(n), 1'b0);
      push(1'b0, 32'h0000_2200 + SW'(n), (n % int'(SETS)) == int'(SETS) - 1);
      strobe(1'b0, 32'h0000_1200 + SW'(n), 32'h0000_2200 + SW'(n));
    end
    @(posedge clk); #1;
    a_s_data  = {32'h0000_FFFF, 32'h0000_EEEE};
    a_s_valid = 1'b1;
    @(posedge clk); #1;
    a_s_valid = 1'b0;
    @(negedge clk);
    chk("a_full_ovf", SW'(a_ovf), 32'd1);
    chk("a_drop_2", SW'(a_drop), 32'd2);
    chk("a_full_hdr_held", a_tdata, hdr_word(16'd3));
    @(posedge clk); #1;
    a_tready = 1'b1;
    drain(1'b0, 200);
    chk("a_seq_pkt5", SW'(a_seq), 32'd5);

    // No header, byte-swapped output
    for (int k = 0; k < int'(SETS); k++) begin
      push(1'b1, vb[k].exp0, 1'b0);
      push(1'b1, vb[k].exp1, k == int'(SETS) - 1);
      strobe(1'b1, vb[k].ch0, vb[k].ch1);
    end
    drain(1'b1, 100);
    chk("b_seq", SW'(b_seq), 32'd1);
    chk("b_drop", SW'(b_drop), 32'd0);

    // Reset while payload word 3 is presented
    @(posedge clk); #1;
    a_tready = 1'b0;
    push(1'b0, hdr_word(16'd5), 1'b0);
    push(1'b0, 32'h0000_1300, 1'b0);
    push(1'b0, 32'h0000_2300, 1'b0);
    push(1'b0, 32'h0000_1301, 1'b0);
    for (int n = 0; n < int'(SETS); n++) begin
      strobe(1'b0, 32'h0000_1300 + SW'(n), 32'h0000_2300 + SW'(n));
    end
    for (int i = 0; i < 100 && !a_tvalid; i++) @(negedge clk);
    chk("a_wait_valid", SW'(a_tvalid), 32'd1);
    @(posedge clk); #1;
    a_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    a_tready = 1'b0;
    @(negedge clk);
    chk("a_word3_data", a_tdata, 32'h0000_2301);
    chk("a_word3_sb", SW'(q_a.size()), '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_rst_mid_tvalid", SW'(a_tvalid), 32'd0);
    chk("a_rst_mid_seq", SW'(a_seq), 32'd0);
    chk("a_rst_mid_drop", SW'(a_drop), 32'd0);
    repeat (3) @(posedge clk);
    q_a.delete();
    q_b.delete();
    @(posedge clk); #1;
    rst_n    = 1'b1;
    a_tready = 1'b1;
    push(1'b0, hdr_word(16'd0), 1'b0);
    for (int n = 0; n < int'(SETS); n++) begin
      push(1'b0, 32'h0000_1400 + SW'(n), 1'b0);
      push(1'b0, 32'h0000_2400 + SW'(n), n == int'(SETS) - 1);
      strobe(1'b0, 32'h0000_1400 + SW'(n), 32'h0000_2400 + SW'(n));
    end
    drain(1'b0, 100);
    chk("a_seq_after_rst", SW'(a_seq), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcm_packetizer.md
Name: pcm_packetizer

Overview:
- Parametrised successor to the single-channel mic-to-packet framing logic.
- Accepts NUM_CH parallel PCM samples per strobe and serialises them channel-interleaved into an internal FIFO.
- Emits fixed-length AXI-Stream packets, each with an optional header word carrying a sequence number.
- Sits between the PDM decimators and packet_gen. Packets are released only when a full payload is buffered, so packet_gen never sees a mid-frame tvalid gap.

Parameters:
- NUM_CH, 2, number of sample channels per strobe (1..8).
- SAMPLE_W, 32, bits per sample and per output word (>=32).
- PAYLOAD_WORDS, 128, payload words per packet; must be a multiple of NUM_CH (elaboration $error otherwise).
- FIFO_DEPTH, 512, FIFO entries; power of 2, >= 2*PAYLOAD_WORDS.
- HDR_EN, 1, 1 = prepend one header word per packet.
- SWAP_BYTES, 1, 1 = byte-reverse each output word (network order).

Ports:
- clk  in  1  single clock domain
- rst_n  in  1  asynchronous, active-low reset
- s_data  in  NUM_CH*SAMPLE_W  channel k occupies bits [k*SAMPLE_W +: SAMPLE_W]
- s_valid  in  1  one-cycle strobe; s_data is valid that cycle only; no ready
- m_axis_tdata  out  SAMPLE_W  output word
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last payload word of a packet
- seq_num  out  16  sequence number of the next packet to start
- drop_count  out  16  sample sets dropped, saturating
- overflow  out  1  one-cycle pulse per dropped sample set

Behaviour:
- Reset (async assert, sync release): all outputs 0. FIFO empty, serializer idle, state IDLE, seq_num=0, drop_count=0.
- Capture: on s_valid, if the serializer is idle AND FIFO free slots >= NUM_CH, latch all of s_data. Channel k is written to the FIFO at cycle t+1+k (one write per cycle, ch0 first). The serializer is busy cycles t+1..t+NUM_CH.
- Drop: on s_valid while the serializer is busy or free slots < NUM_CH:
  - the whole set is discarded (never partial);
  - overflow=1 at t+1;
  - drop_count increments, saturating at 16'hFFFF.
- FIFO: first-word-fall-through. A simultaneous read and write leaves the count unchanged. Free slots = FIFO_DEPTH - count, including pending serializer writes.
- Output FSM:
  - IDLE: tvalid=0. When count >= PAYLOAD_WORDS, go to HDR next cycle (HDR_EN=1) or to PAY (HDR_EN=0).
  - HDR: tvalid=1. tdata = zero-extended {8'hA5, 8'(NUM_CH), seq_num}, byte-swapped if SWAP_BYTES. On tready, go to PAY.
  - PAY: tvalid=1 continuously. tdata = FIFO head, optionally byte-swapped. Each handshake pops one word. tlast=1 on word PAYLOAD_WORDS-1 only. On the handshake with tlast: seq_num increments (wraps 16'hFFFF->0), state returns to IDLE.
- Since PAYLOAD_WORDS words were present at packet start, PAY never underruns and tvalid never drops mid-packet.
- AXIS rules: with tvalid=1 and tready=0, tdata/tlast hold stable. tvalid never deasserts without a handshake.
- Inter-packet gap: at least one IDLE cycle between a tlast handshake and the next HDR/PAY.
- Channel alignment is preserved: every packet payload starts at ch0, because PAYLOAD_WORDS % NUM_CH == 0 and sets are never split.
- Byte swap: out byte i = in byte (SAMPLE_W/8-1-i).
- Reset mid-packet: tvalid drops immediately. The partial packet is abandoned; downstream treats it as truncated. Restart begins from seq_num=0.

Test Plan:
- NUM_CH=2, PAYLOAD_WORDS=8, HDR_EN=1, SWAP_BYTES=0. Apply 4 strobes, data ch0=0x1000+n, ch1=0x2000+n, tready=1 -> one packet: header 0xA5020000, then 0x1000,0x2000,0x1001,...,0x2003; tlast on 9th word; seq_num becomes 1.
- Same config, tready toggling 1/0 every cycle -> identical word sequence; tdata and tlast stable during stalls; no tvalid gap.
- Two strobes 1 cycle apart with NUM_CH=2 -> second set dropped; overflow pulses once; drop_count=1; FIFO holds only 2 words.
- tready=0 held until FIFO full, then one more strobe -> set dropped, drop_count increments. Release tready -> packets drain in order with consecutive seq_num.
- HDR_EN=0, SWAP_BYTES=1, sample 0x11223344 -> first tdata = 0x44332211; no header word.
- Deassert rst_n during PAY word 3 -> tvalid=0, seq_num=0, drop_count=0 asynchronously. After release, the next packet is a full, correct packet with header seq 0.
